hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It decodes source and destination registers of the instruction in ID and tracks the destinations of the instructions in EX, MEM and WB in an internal scoreboard pipe. From these it generates the load-use stall, the taken-branch flush, the global freeze and registered forwarding selects for the EX stage. It sits beside the ID/EX pipeline register and drives the PC, IF/ID and ID/EX enable and clear inputs.

## Interface
Parameters:
- XLEN, 32, instruction width (fixed at 32; present for package consistency)
- NREG_W, 5, register index width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_inst  in  32  instruction word in ID
- branch_taken  in  1  EX resolved a taken branch, JAL or JALR redirect this cycle
- mem_stall  in  1  data memory not ready; whole pipeline must freeze
- freeze  out  1  hold every pipeline register and the PC (= mem_stall)
- stall_id  out  1  hold PC and IF/ID (load-use)
- flush_id  out  1  clear IF/ID (taken branch)
- bubble_ex  out  1  load a NOP into ID/EX
- fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- fwd_b_sel  out  2  EX operand B source, same encoding

## Operation
- ID decode by opcode [6:0]:
  - LUI, AUIPC, JAL: rd only.
  - JALR, LOAD, OP-IMM: rd and rs1.
  - BRANCH, STORE: rs1 and rs2.
  - OP: rd, rs1 and rs2.
  - Any other opcode, or id_valid=0: no rd, no rs.
  - Index 0 always counts as "none".
- Scoreboard: three slots (EX, MEM, WB), each holding {valid, rd[4:0], is_load}.
- load_use (combinational) = id_valid & an ID source matches the EX slot rd & EX is_load & EX valid.
- Priority, highest first:
  - mem_stall: freeze=1, all other control outputs 0, and all state (slots, fwd sels) holds.
  - branch_taken: flush_id=1, bubble_ex=1, stall_id=0. The ID instruction is discarded, so a load-use in the same cycle is ignored.
  - load_use: stall_id=1, bubble_ex=1.
  - Otherwise: normal advance.
- Advance, on any cycle with mem_stall=0:
  - WB slot takes the MEM slot; MEM slot takes the EX slot.
  - EX slot takes the decoded ID info, or invalid if bubble_ex=1.
- fwd_x_sel is registered and computed for the instruction entering EX, comparing its source against:
  - the current EX slot, which becomes MEM: gives 01, only if that slot is not a load;
  - the current MEM slot, which becomes WB: gives 10.
  - 01 has priority over 10 when both match. No match gives 00. The value is forced to 00 when bubble_ex=1.

## Timing
- Reset: all slots invalid, fwd_a_sel=fwd_b_sel=00. Combinational outputs follow their inputs, so freeze=mem_stall and stall_id/flush_id/bubble_ex are 0 with empty slots.
- Load-use costs exactly 1 bubble. On the next cycle the load sits in MEM, the consumer is re-presented in ID, and it is issued with sel=10.
- Back-to-back dependent ALU ops give sel=01 with zero stall. A distance of 2 gives sel=10. A distance of 3 or more gives 00 (the regfile writes first and reads second).
- branch_taken held high across a mem_stall is acted on only in the first cycle with mem_stall=0.
- Reset asserted mid-stall immediately clears the slots and sels. There is no partial state.

## Structure
- Shared package rv32i_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_BRANCH, OP_STORE, OP_OP);
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the scoreboard slot struct.
- One sub-module, inst_rw_decode: combinational rd/rs1/rs2 plus use flags and is_load from the instruction word.

## Test plan
- Reset with mem_stall=0 -> all outputs 0, sels 00. Issue addi x1 then add x2,x1,x1 -> second op in EX with fwd_a_sel=fwd_b_sel=01, no stall.
- lw x5,0(x0) then add x6,x5,x0 -> 1 cycle with stall_id=1 and bubble_ex=1; add then enters EX with fwd_a_sel=10, fwd_b_sel=00.
- lw x5 followed by a taken branch in EX while the dependent add is in ID, same cycle -> flush_id=1, bubble_ex=1, stall_id=0.
- add x0,... then add x3,x0,x0 -> no forwarding (sels 00), since x0 is never tracked.
- mem_stall=1 for 3 cycles mid-sequence -> freeze=1, sels and slots unchanged; forwarding resumes correctly after release.
- Two writers of x7 at distance 1 and 2, then a reader of x7 -> sel=01 (newest wins).

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, forwarding-select encodings, scoreboard slot.
// Pure declarations plus one combinational helper; no state, no latency, no flow control.
package rv32i_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } slot_t;

    // The EX occupant moves to MEM next cycle, so it is the newest producer;
    // a load there has no data yet and is covered by the load-use stall.
    function automatic logic [1:0] fwd_pick(input logic has_rs, input logic [REG_W-1:0] rs,
                                            input slot_t ex, input slot_t mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (has_rs && ex.valid && !ex.is_load && ex.rd == rs)
            sel = FWD_MEM;
        else if (has_rs && mem.valid && mem.rd == rs)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/inst_rw_decode.sv
// Register read/write decode of one RV32I instruction word; x0 is never reported.
// Purely combinational, zero latency, no backpressure.
module inst_rw_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG_W = 5
) (
    input  logic              valid,
    input  logic [XLEN-1:0]   inst,
    output logic [NREG_W-1:0] rd,
    output logic [NREG_W-1:0] rs1,
    output logic [NREG_W-1:0] rs2,
    output logic              has_rd,
    output logic              has_rs1,
    output logic              has_rs2,
    output logic              is_load
);

    logic use_rd, use_rs1, use_rs2;
    logic unused_bits;

    assign rd  = inst[7  +: NREG_W];
    assign rs1 = inst[15 +: NREG_W];
    assign rs2 = inst[20 +: NREG_W];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC, OP_JAL:   use_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_OPIMM: begin use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_BRANCH, OP_STORE:        begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_OP:                      begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default: ;
        endcase
    end

    assign has_rd  = valid & use_rd  & (|rd);
    assign has_rs1 = valid & use_rs1 & (|rs1);
    assign has_rs2 = valid & use_rs2 & (|rs2);
    assign is_load = valid & (inst[6:0] == OP_LOAD);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, memory freeze, EX forwarding selects.
// Control outputs are combinational; forwarding selects are registered with the ID/EX advance; mem_stall freezes all state.
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_inst,
    input  logic            branch_taken,
    input  logic            mem_stall,
    output logic            freeze,
    output logic            stall_id,
    output logic            flush_id,
    output logic            bubble_ex,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);

    logic [NREG_W-1:0] id_rd, id_rs1, id_rs2;
    logic id_has_rd, id_has_rs1, id_has_rs2, id_is_load;
    slot_t ex_slot, mem_slot, wb_slot, ex_next;
    logic load_use;
    logic unused_wb;

    inst_rw_decode #(.XLEN(XLEN), .NREG_W(NREG_W)) u_dec (
        .valid   (id_valid),
        .inst    (id_inst),
        .rd      (id_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .has_rd  (id_has_rd),
        .has_rs1 (id_has_rs1),
        .has_rs2 (id_has_rs2),
        .is_load (id_is_load)
    );

    assign load_use = id_valid & ex_slot.valid & ex_slot.is_load &
                      ((id_has_rs1 & (id_rs1 == ex_slot.rd)) |
                       (id_has_rs2 & (id_rs2 == ex_slot.rd)));

    always_comb begin
        freeze    = mem_stall;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (!mem_stall) begin
            if (branch_taken) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_comb begin
        ex_next = '0;
        if (!bubble_ex) begin
            ex_next.valid   = id_has_rd;
            ex_next.rd      = id_rd;
            ex_next.is_load = id_is_load & id_has_rd;
        end
    end

    // WB occupant is kept for visibility only: the regfile writes before it is read.
    assign unused_wb = ^wb_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (!mem_stall) begin
            wb_slot   <= mem_slot;
            mem_slot  <= ex_slot;
            ex_slot   <= ex_next;
            fwd_a_sel <= bubble_ex ? FWD_RF : fwd_pick(id_has_rs1, id_rs1, ex_slot, mem_slot);
            fwd_b_sel <= bubble_ex ? FWD_RF : fwd_pick(id_has_rs2, id_rs2, ex_slot, mem_slot);
        end
    end

endmodule
